// File: rtl/stack_pkg.sv
// Shared encodings for the stack pointer unit: FSM states and grow-direction constants.
package stack_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    FAULT  = 1'b1
  } stack_state_e;

  localparam logic GROW_UP = 1'b0;
  localparam logic GROW_DN = 1'b1;

endpackage

// File: rtl/stack_bound_check.sv
// Combinational bound checks for push, pop and load.
// Comparisons are carried out one bit wider than the pointer so they never wrap.
module stack_bound_check #(
  parameter int ADDR_WIDTH  = 20,
  parameter int STACK_DEPTH = 256,
  parameter int STEP_W      = 3
) (
  input  logic [ADDR_WIDTH-1:0] count,
  input  logic [STEP_W-1:0]     step,
  input  logic [ADDR_WIDTH-1:0] offset,
  output logic                  push_ok,
  output logic                  pop_ok,
  output logic                  load_ok
);

  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(STACK_DEPTH);

  logic [ADDR_WIDTH:0] w_count_x;
  logic [ADDR_WIDTH:0] w_step_x;
  logic [ADDR_WIDTH:0] w_offset_x;
  logic [ADDR_WIDTH:0] w_sum_x;

  // Widen operands and evaluate every bound in parallel.
  always_comb begin
    w_count_x  = {1'b0, count};
    w_step_x   = (ADDR_WIDTH+1)'(step);
    w_offset_x = {1'b0, offset};
    w_sum_x    = w_count_x + w_step_x;
    push_ok    = (w_sum_x <= DEPTH_X);
    pop_ok     = (w_count_x >= w_step_x);
    load_ok    = (w_offset_x <= DEPTH_X);
  end

endmodule

// File: rtl/stack_pointer_unit.sv
// Stack pointer with occupancy tracking, sticky overflow/underflow flags and
// a NORMAL/FAULT state machine. The pointer is derived from the occupancy.
module stack_pointer_unit
  import stack_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 20,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE  = 20'h00000,
  parameter int                    STACK_DEPTH = 256,
  parameter logic                  GROW_DOWN   = 1'b0,
  parameter int                    STEP_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [STEP_W-1:0]     step,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  clear_fault,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  fault
);

  stack_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [STEP_W-1:0]     w_step_eff;
  logic [ADDR_WIDTH-1:0] w_step_x;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic                  w_load_ok;

  // A step of zero is treated as a single word; load offset is measured in the growth direction.
  always_comb begin
    w_step_eff = (step == '0) ? STEP_W'(1) : step;
    w_step_x   = ADDR_WIDTH'(w_step_eff);
    w_offset   = (GROW_DOWN == GROW_DN) ? (STACK_BASE - load_addr) : (load_addr - STACK_BASE);
  end

  stack_bound_check #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH),
    .STEP_W      (STEP_W)
  ) u_bound (
    .count   (r_count),
    .step    (w_step_eff),
    .offset  (w_offset),
    .push_ok (w_push_ok),
    .pop_ok  (w_pop_ok),
    .load_ok (w_load_ok)
  );

  // Occupancy, sticky flags and fault state; load outranks push+pop, which outranks push, then pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= NORMAL;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        NORMAL: begin
          if (clear_fault) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
          end
          if (load) begin
            if (w_load_ok) begin
              r_count <= w_offset;
            end else begin
              r_overflow <= 1'b1;
              r_state    <= FAULT;
            end
          end else if (push && pop) begin
            r_count <= r_count;
          end else if (push) begin
            if (w_push_ok) begin
              r_count <= r_count + w_step_x;
            end else begin
              r_overflow <= 1'b1;
              r_state    <= FAULT;
            end
          end else if (pop) begin
            if (w_pop_ok) begin
              r_count <= r_count - w_step_x;
            end else begin
              r_underflow <= 1'b1;
              r_state     <= FAULT;
            end
          end
        end
        FAULT: begin
          if (clear_fault) begin
            r_state     <= NORMAL;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
          end
        end
        default: r_state <= NORMAL;
      endcase
    end
  end

  // Pointer and status views derived from the registered occupancy.
  always_comb begin
    addr_out  = (GROW_DOWN == GROW_DN) ? (STACK_BASE - r_count) : (STACK_BASE + r_count);
    count     = r_count;
    full      = (r_count == ADDR_WIDTH'(STACK_DEPTH));
    empty     = (r_count == '0);
    overflow  = r_overflow;
    underflow = r_underflow;
    fault     = (r_state == FAULT);
  end

endmodule

// File: doc/stack_pointer_unit.md
STACK_POINTER_UNIT -- requirements
Module: stack_pointer_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, pointer width in bits.
REQ-002 SHALL have parameter STACK_BASE, default 20'h00000, address of the empty-stack pointer.
REQ-003 SHALL have parameter STACK_DEPTH, default 256, maximum occupancy in words (1..2^ADDR_WIDTH-1).
REQ-004 SHALL have parameter GROW_DOWN, default 0; 0 means the stack grows to higher addresses, 1 means it grows to lower addresses.
REQ-005 SHALL have parameter STEP_W, default 3, width of the step input.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 push  input  1  advance pointer by step words.
REQ-009 pop  input  1  retract pointer by step words.
REQ-010 step  input  STEP_W  words per push/pop; 0 treated as 1.
REQ-011 load  input  1  load pointer from load_addr.
REQ-012 load_addr  input  ADDR_WIDTH  absolute pointer value to load.
REQ-013 clear_fault  input  1  leave FAULT, clear sticky flags.
REQ-014 addr_out  output  ADDR_WIDTH  current stack pointer.
REQ-015 count  output  ADDR_WIDTH  current occupancy in words.
REQ-016 full  output  1  count == STACK_DEPTH.
REQ-017 empty  output  1  count == 0.
REQ-018 overflow  output  1  sticky; a push was rejected.
REQ-019 underflow  output  1  sticky; a pop was rejected.
REQ-020 fault  output  1  FSM is in FAULT.

Function
REQ-021 Internal state SHALL be count plus a two-state FSM, NORMAL and FAULT; addr_out SHALL be STACK_BASE+count (GROW_DOWN=0) or STACK_BASE-count (GROW_DOWN=1), modulo 2^ADDR_WIDTH, combinational from count.
REQ-022 All register updates SHALL take effect on the rising clk edge, so addr_out reflects an operation one cycle after it is sampled.
REQ-023 In NORMAL, the priority SHALL be load > push&pop > push > pop.
REQ-024 Push alone: if count+step <= STACK_DEPTH, count += step; otherwise count is unchanged, overflow is set, and the FSM moves to FAULT.
REQ-025 Pop alone: if count >= step, count -= step; otherwise count is unchanged, underflow is set, and the FSM moves to FAULT.
REQ-026 Push and pop asserted in the same cycle SHALL leave count unchanged and SHALL NOT set any flag, regardless of full/empty.
REQ-027 Load SHALL compute the offset from STACK_BASE in the growth direction; if the offset is <= STACK_DEPTH, count = offset; otherwise count is unchanged, overflow is set, and the FSM moves to FAULT.
REQ-028 A push that reaches exactly STACK_DEPTH SHALL succeed and assert full; a pop that reaches exactly 0 SHALL succeed and assert empty.
REQ-029 In FAULT, push, pop and load SHALL be ignored, and count SHALL hold.
REQ-030 clear_fault in FAULT SHALL return the FSM to NORMAL and clear overflow and underflow on the same edge; count SHALL be retained; no other operation is executed in that cycle.
REQ-031 clear_fault in NORMAL SHALL clear the sticky flags and SHALL NOT block a concurrent operation.
REQ-032 Arithmetic SHALL be done at ADDR_WIDTH+1 bits so that the bound checks never wrap.

Reset
REQ-033 Reset SHALL be asynchronous on the rising edge of reset and SHALL force count=0, FSM=NORMAL, overflow=0, underflow=0.
REQ-034 Outputs during and after reset SHALL be addr_out=STACK_BASE, count=0, empty=1, full=0, fault=0.
REQ-035 Reset asserted mid-operation SHALL discard that operation.

Structure
REQ-036 A package stack_pkg SHALL hold the FSM state encoding (NORMAL=0, FAULT=1) and the grow-direction constants GROW_UP=0 and GROW_DN=1.
REQ-037 The bound checks SHALL be isolated in one combinational sub-module, stack_bound_check (inputs count, step, offset; outputs push_ok, pop_ok, load_ok); all else resides in stack_pointer_unit.

Verification
REQ-038 Reset, then 3 pushes with step=1 (defaults) -> addr_out 00000, 00001, 00002, 00003; count=3; empty=0.
REQ-039 GROW_DOWN=1, STACK_BASE=20'h00100, push step=4 then pop step=1 -> addr_out 000FC then 000FD.
REQ-040 STACK_DEPTH=8, push step=7, then push step=2 -> count=7, then overflow=1, fault=1, count=7; a following push is ignored; clear_fault -> fault=0, overflow=0, count=7.
REQ-041 Empty stack, pop step=1 -> underflow=1, fault=1, addr_out=STACK_BASE; push and pop in the same cycle at count=STACK_DEPTH -> no change, no flags.
REQ-042 load load_addr=STACK_BASE+5 -> count=5; load with offset STACK_DEPTH+1 -> overflow=1, count=5; step=0 push -> count+1.
REQ-043 Reset asserted asynchronously mid-cycle while count=5 and fault=1 -> outputs return to reset values immediately, without waiting for clk.
